msrv32_pc_fetch: RTL
====================

Name: msrv32_pc_fetch

Overview:
- Program-counter and instruction-fetch address stage of the msrv32 core.
- Sits directly downstream of msrv32_bu and consumes branch_taken_out together with the branch/jump target from the immediate adder.
- Resolves next-PC priority (trap > pending redirect > mret/branch > sequential) and drives the instruction-bus address.
- Handles bus wait states, holds redirects that arrive during a stall, and flags the wrong-path instruction.

Parameters:
RESET_PC, 32'h0000_0000, boot address loaded into iaddr_out/pc_out on reset

Ports:
clk_in  input  1  core clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
branch_taken_in  input  1  from msrv32_bu branch_taken_out; redirect to target_addr_in
target_addr_in  input  32  branch/JAL/JALR target from immediate adder
mret_in  input  1  return from trap; redirect to epc_in
epc_in  input  32  exception PC from CSR file
trap_taken_in  input  1  trap request; redirect to trap_addr_in
trap_addr_in  input  32  trap vector; bits [1:0] forced to 00 internally
hready_in  input  1  instruction bus ready; 0 = wait state
iaddr_out  output  32  registered fetch address to instruction bus
pc_out  output  32  PC of instruction in execute
pc_plus_4_out  output  32  pc_out + 4 (mod 2^32), combinational from pc_out
ivalid_out  output  1  instruction in execute is valid (not bubble/wrong-path)
flush_out  output  1  one-cycle pulse: wrong-path instruction discarded
misaligned_instr_out  output  1  one-cycle pulse: redirect target bit[1]=1

Behaviour:
- Reset (async, rst_n_in=0): iaddr_out=RESET_PC, pc_out=RESET_PC, ivalid_out=0, flush_out=0, misaligned_instr_out=0, pend_valid=0, state=BOOT. Mid-operation reset discards any pending redirect immediately.
- FSM states: BOOT, RUN, STALL, STALL_PEND.
  - BOOT -> RUN on the first edge with hready_in=1. No redirect is accepted except a trap.
  - RUN -> STALL when hready_in=0 and no redirect.
  - RUN -> STALL_PEND when hready_in=0 and a redirect is present.
  - STALL -> STALL_PEND when a redirect arrives.
  - STALL/STALL_PEND -> RUN on hready_in=1.
- Redirect qualification:
  - branch_taken_in and mret_in are honoured only when ivalid_out=1.
  - trap_taken_in is always honoured.
  - Same-cycle priority: trap > mret > branch.
- Redirect address:
  - Branch target = target_addr_in with bit0 cleared.
  - mret target = epc_in.
  - Trap target = {trap_addr_in[31:2],2'b00}.
- Edge with hready_in=1:
  - pc_out <= iaddr_out.
  - iaddr_out <= next_pc, selected as follows:
    - trap present: trap target, and pend is cleared.
    - else pend_valid=1: pend_addr, and pend is cleared.
    - else qualified mret/branch present: its target.
    - else: iaddr_out+4, wrapping FFFF_FFFC -> 0000_0000.
  - ivalid_out <= 1, unless a redirect or pend was applied at this edge or state was BOOT; in those cases ivalid_out <= 0.
  - flush_out <= 1 exactly when a redirect or pend was applied at this edge, else 0.
- Edge with hready_in=0:
  - iaddr_out and pc_out hold; ivalid_out <= 0; flush_out <= 0.
  - Redirect present: pend_addr/pend_valid captured if pend_valid=0, or overwritten if the source is a trap.
  - A mret/branch redirect never overwrites an existing pend.
- Misalignment:
  - Applies to a resolved mret/branch target with bit[1]=1 (after the bit0 clear).
  - The target is not loaded: iaddr_out follows the sequential rule.
  - misaligned_instr_out <= 1 for one cycle.
  - Recovery is the trap unit's responsibility via a later trap_taken_in.
  - Not checked for trap targets, which are always aligned.
- Latency:
  - Redirect observed in cycle N appears on iaddr_out after edge N+1.
  - That edge's pc_out instruction is marked invalid (1-cycle bubble).

Test Plan:
- Reset with RESET_PC=0x100, hready_in=1, no redirects -> iaddr_out 0x100, 0x104, 0x108 on successive edges; ivalid_out 0 in the BOOT cycle then 1; pc_out lags iaddr_out by one cycle; pc_plus_4_out = pc_out+4.
- Once ivalid_out=1: branch_taken_in=1, target_addr_in=0x0000_2001 -> iaddr_out=0x2000 next edge; flush_out=1 and ivalid_out=0 for exactly one cycle; then sequential 0x2004.
- hready_in=0 for 3 cycles with branch_taken_in=1 (target 0x400) in the first stall cycle -> iaddr_out/pc_out frozen; on hready_in=1, iaddr_out=0x400 and flush_out pulses once.
- Same cycle: trap_taken_in=1 (trap_addr_in=0x8000_0003), branch_taken_in=1, mret_in=1 -> iaddr_out=0x8000_0000; branch and mret ignored. Trap arriving while a branch is pending in STALL_PEND -> trap address wins.
- Branch to target 0x0000_1006 -> misaligned_instr_out=1 for one cycle; iaddr_out advances sequentially; no flush_out.
- iaddr_out=0xFFFF_FFFC, hready_in=1 -> next iaddr_out=0x0000_0000. Asserting rst_n_in=0 mid-stall with pend_valid set -> outputs return to reset values immediately; no redirect occurs after release.

Source files
------------

// File: rtl/msrv32_pc_fetch.sv
// Program-counter / instruction-fetch address stage of the msrv32 core.
// Resolves next-PC priority, rides out bus wait states and tags wrong-path fetches.
module msrv32_pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        branch_taken_in,
    input  logic [31:0] target_addr_in,
    input  logic        mret_in,
    input  logic [31:0] epc_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_addr_in,
    input  logic        hready_in,
    output logic [31:0] iaddr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus_4_out,
    output logic        ivalid_out,
    output logic        flush_out,
    output logic        misaligned_instr_out
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        STALL,
        STALL_PEND
    } state_t;

    state_t      r_state;
    logic [31:0] r_iaddr;
    logic [31:0] r_pc;
    logic        r_ivalid;
    logic        r_flush;
    logic        r_misaligned;
    logic        r_pend_valid;
    logic [31:0] r_pend_addr;

    logic [31:0] w_trap_tgt;
    logic [31:0] w_branch_tgt;
    logic        w_qual_mret;
    logic        w_qual_branch;
    logic        w_mb_present;
    logic [31:0] w_mb_tgt;
    logic        w_mb_valid;
    logic        w_mb_misaligned;
    logic        w_applied;
    logic        w_will_pend;
    logic        w_mis_pulse;
    logic [31:0] w_seq_pc;
    logic [31:0] w_next_pc;

    assign w_trap_tgt    = {trap_addr_in[31:2], 2'b00};
    assign w_branch_tgt  = {target_addr_in[31:1], 1'b0};

    // mret/branch come from the instruction in execute, so a bubble cannot redirect
    assign w_qual_mret   = mret_in & r_ivalid;
    assign w_qual_branch = branch_taken_in & r_ivalid;
    assign w_mb_present  = w_qual_mret | w_qual_branch;
    assign w_mb_tgt      = w_qual_mret ? epc_in : w_branch_tgt;

    // A misaligned mret/branch target is dropped; the trap unit recovers later
    assign w_mb_misaligned = w_mb_present & w_mb_tgt[1];
    assign w_mb_valid      = w_mb_present & ~w_mb_tgt[1];

    assign w_applied   = trap_taken_in | r_pend_valid | w_mb_valid;
    assign w_will_pend = trap_taken_in | r_pend_valid | w_mb_valid;
    assign w_mis_pulse = w_mb_misaligned & ~trap_taken_in & ~r_pend_valid;
    assign w_seq_pc    = r_iaddr + 32'd4;

    always_comb begin
        w_next_pc = w_seq_pc;
        if (trap_taken_in)
            w_next_pc = w_trap_tgt;
        else if (r_pend_valid)
            w_next_pc = r_pend_addr;
        else if (w_mb_valid)
            w_next_pc = w_mb_tgt;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= BOOT;
            r_iaddr      <= RESET_PC;
            r_pc         <= RESET_PC;
            r_ivalid     <= 1'b0;
            r_flush      <= 1'b0;
            r_misaligned <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
        end else begin
            r_misaligned <= w_mis_pulse;
            if (hready_in) begin
                r_pc         <= r_iaddr;
                r_iaddr      <= w_next_pc;
                r_ivalid     <= ~w_applied & (r_state != BOOT);
                r_flush      <= w_applied;
                r_pend_valid <= 1'b0;
                r_state      <= RUN;
            end else begin
                r_ivalid <= 1'b0;
                r_flush  <= 1'b0;
                // A trap always overwrites the held redirect; mret/branch only fill an empty slot
                if (trap_taken_in) begin
                    r_pend_addr  <= w_trap_tgt;
                    r_pend_valid <= 1'b1;
                end else if (w_mb_valid && !r_pend_valid) begin
                    r_pend_addr  <= w_mb_tgt;
                    r_pend_valid <= 1'b1;
                end
                case (r_state)
                    BOOT:       r_state <= BOOT;
                    RUN, STALL: r_state <= w_will_pend ? STALL_PEND : STALL;
                    STALL_PEND: r_state <= STALL_PEND;
                    default:    r_state <= BOOT;
                endcase
            end
        end
    end

    assign iaddr_out            = r_iaddr;
    assign pc_out               = r_pc;
    assign pc_plus_4_out        = r_pc + 32'd4;
    assign ivalid_out           = r_ivalid;
    assign flush_out            = r_flush;
    assign misaligned_instr_out = r_misaligned;

endmodule
